alu_wb_param: RTL and testbench
===============================

Name: alu_wb_param

Overview:
Parametrised WIDTH-bit ALU slave on a Wishbone pipelined bus for the 6502 datapath. Holds operand registers A and B and a 6502-style FLAGS register.
- Single-cycle ops (ADD/ADC/SBC/AND/OR/XOR/ASL/LSR) return their result on a read of the op address and update FLAGS.
- An optional multi-cycle shift-add multiplier uses o_wb_stall to hold off the bus while it runs.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 8.
ADDR_W, 4, width of i_wb_addr.

Ports:
i_clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
i_wb_stb  input  1  request strobe
i_wb_we  input  1  1 = write, 0 = read
i_wb_addr  input  ADDR_W  register/op address
i_wb_data  input  WIDTH  write data
o_wb_ack  output  1  request completed
o_wb_stall  output  1  slave cannot accept a request this cycle
o_wb_data  output  WIDTH  read data, registered

Interface decision: one clock, i_clk; reset is asynchronous and active-high, port name reset.

Behaviour:
- Accept condition: i_wb_stb && !o_wb_stall.
- Ack: o_wb_ack is asserted exactly 1 cycle after each accepted request, reads and writes alike.
- Read data: o_wb_data is updated on the accept edge for reads and is valid alongside ack. It holds its value otherwise; no tristate.
- Reset (asynchronous): A, B, FLAGS, product, o_wb_data, o_wb_ack and o_wb_stall all go to 0; FSM goes to IDLE.
- FLAGS layout: bit0 C, bit1 Z, bit6 V, bit7 N; other bits read 0. Reads are zero-extended to WIDTH.
- Write map:
  - 0x0: A.
  - 0x1: B.
  - 0x2: FLAGS (only bits 0, 1, 6, 7 are stored).
  - 0x3: MUL_GO (data ignored).
  - Other addresses: acked, no effect.
- Read map:
  - 0x0: A. 0x1: B. 0x2: FLAGS.
  - 0x4: product low WIDTH bits. 0x5: product high WIDTH bits.
  - 0x8 ADD: A+B, carry-in 0.
  - 0x9 ADC: A+B+C.
  - 0xA SBC: A+~B+C (C=1 means no borrow).
  - 0xB AND. 0xC OR. 0xD XOR.
  - 0xE ASL: A<<1, C=A[WIDTH-1].
  - 0xF LSR: A>>1, C=A[0].
  - Others return 0.
- Flag updates, committed on the same edge as o_wb_data:
  - ADD/ADC/SBC update C, Z, V, N. V = signed overflow; N = result MSB.
  - AND/OR/XOR update Z, N.
  - ASL/LSR update C, Z, N.
- A/B/FLAGS are never modified by op reads.
- Back-to-back ordering: a write accepted in cycle n is visible to an op read accepted in cycle n+1. Example: write FLAGS then ADC uses the new C.
- Multiplier FSM: IDLE -> BUSY on an accepted MUL_GO.
  - On entry: latch A and B, clear the product, load count = WIDTH.
  - BUSY: one shift-add step per cycle; o_wb_stall=1 for exactly WIDTH cycles starting the cycle after accept; no requests accepted.
  - BUSY -> IDLE when count reaches 0: product registers committed, Z = (product==0), stall drops the same cycle.
  - The ack for MUL_GO still occurs 1 cycle after accept, concurrent with the first BUSY cycle.
  - A/B writes cannot occur mid-operation because the bus is stalled.
  - Reset during BUSY: immediate return to IDLE, product = 0, stall = 0.
- i_wb_stb held while stalled: the request is accepted in the first cycle stall is low.

Optional Feature:
ALU_MUL_EN.
- Defined: multiplier FSM, product registers and stall logic are present as described.
- Undefined: o_wb_stall is tied 0; MUL_GO writes are acked with no effect; reads of 0x4/0x5 return 0; no product registers are built.

Decomposition:
- Shared package alu_pkg:
  - address constants ADDR_A, ADDR_B, ADDR_FLAGS, ADDR_MUL_GO, ADDR_PROD_LO, ADDR_PROD_HI, ADDR_ADD … ADDR_LSR;
  - flag bit index constants FLAG_C, FLAG_Z, FLAG_V, FLAG_N;
  - the FSM state enum.
- Sub-module alu_mul_seq: sequential WIDTH×WIDTH shift-add multiplier with start/busy/done and a 2*WIDTH product. Instantiated only under ALU_MUL_EN.
- Op decode and flag generation stay in the top module.

Test Plan (WIDTH=8):
- Write A=0x50, B=0x50; read 0x8 -> data 0xA0, FLAGS=0xC0 (N=1, V=1, C=0, Z=0); ack exactly 1 cycle after each stb.
- A=0xFF, B=0x01, read 0x8 -> 0x00 with C=1, Z=1. Then write A=0x00, B=0x00 and read 0x9 -> 0x01 with C=0, Z=0.
- Write FLAGS=0x01, A=0x05, B=0x07; read 0xA -> 0xFE, C=0, N=1. Write FLAGS=0x01, A=0x07, B=0x05; read 0xA -> 0x02, C=1.
- A=0x81: read 0xE -> 0x02 with C=1; read 0xF -> 0x40 with C=1; A unchanged (read 0x0 -> 0x81).
- ALU_MUL_EN: A=0xFF, B=0xFF, write 0x3 -> stall high for exactly 8 cycles, a read of 0x0 held on stb meanwhile is accepted only afterward; then read 0x4 -> 0x01, 0x5 -> 0xFE.
- Assert reset 3 cycles into a multiply -> stall, ack, data and product go 0 immediately; after release, read 0x4 -> 0x00; a new MUL_GO runs normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the Wishbone ALU slave: register/op address map, FLAGS bit
// positions and the multiplier sequencer state type.
package alu_pkg;

  localparam int unsigned FLAGS_W = 8;

  localparam logic [3:0] ADDR_A       = 4'h0;
  localparam logic [3:0] ADDR_B       = 4'h1;
  localparam logic [3:0] ADDR_FLAGS   = 4'h2;
  localparam logic [3:0] ADDR_MUL_GO  = 4'h3;
  localparam logic [3:0] ADDR_PROD_LO = 4'h4;
  localparam logic [3:0] ADDR_PROD_HI = 4'h5;
  localparam logic [3:0] ADDR_ADD     = 4'h8;
  localparam logic [3:0] ADDR_ADC     = 4'h9;
  localparam logic [3:0] ADDR_SBC     = 4'hA;
  localparam logic [3:0] ADDR_AND     = 4'hB;
  localparam logic [3:0] ADDR_OR      = 4'hC;
  localparam logic [3:0] ADDR_XOR     = 4'hD;
  localparam logic [3:0] ADDR_ASL     = 4'hE;
  localparam logic [3:0] ADDR_LSR     = 4'hF;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  // Only C, Z, V and N exist; the remaining FLAGS bits always read 0.
  localparam logic [FLAGS_W-1:0] FLAGS_MASK = 8'hC3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/alu_wb_param_if.sv
// Wishbone pipelined bus bundle between a master and the ALU slave.
interface alu_wb_param_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) ();

  logic              i_wb_stb;
  logic              i_wb_we;
  logic [ADDR_W-1:0] i_wb_addr;
  logic [WIDTH-1:0]  i_wb_data;
  logic              o_wb_ack;
  logic              o_wb_stall;
  logic [WIDTH-1:0]  o_wb_data;

  modport master (
    output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Sequential WIDTH x WIDTH shift-add multiplier: one partial product per cycle,
// busy for exactly WIDTH cycles after start, product committed on the last step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done_c,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_next_c
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PROD_W = 2 * WIDTH;

  mul_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [PROD_W-1:0] mcand;
  logic [WIDTH-1:0]  mplier;
  logic [PROD_W-1:0] acc;

  assign product_next_c = acc + (mplier[0] ? mcand : '0);
  assign done_c         = (state == ST_BUSY) && (count == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_BUSY;
            busy    <= 1'b1;
            count   <= CNT_W'(WIDTH);
            mcand   <= PROD_W'(a);
            mplier  <= b;
            acc     <= '0;
            product <= '0;
          end
        end
        ST_BUSY: begin
          acc    <= product_next_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CNT_W'(1);
          if (done_c) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            product <= product_next_c;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_param.sv
// WIDTH-bit ALU slave on a pipelined Wishbone bus with A/B operands and 6502-style FLAGS.
// Define ALU_MUL_EN to build the multi-cycle multiplier (MUL_GO, product regs, stall).
module alu_wb_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic           i_clk,
  input  logic           reset,
  alu_wb_param_if.slave  wb
);

  logic [WIDTH-1:0]   reg_a;
  logic [WIDTH-1:0]   reg_b;
  logic [FLAGS_W-1:0] flags;
  logic               ack;
  logic [WIDTH-1:0]   rdata;
  logic               stall;
  logic               accept_c;
  logic [WIDTH-1:0]   addend_c;
  logic               cin_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   rdata_c;
  logic [FLAGS_W-1:0] flags_rd_c;
  logic               op_c;

  assign accept_c      = wb.i_wb_stb && !stall;
  assign wb.o_wb_ack   = ack;
  assign wb.o_wb_data  = rdata;
  assign wb.o_wb_stall = stall;

`ifdef ALU_MUL_EN
  logic               mul_go_c;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_next_c;

  assign mul_go_c = accept_c && wb.i_wb_we && (wb.i_wb_addr == ADDR_W'(ADDR_MUL_GO));

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk            (i_clk),
    .rst            (reset),
    .start          (mul_go_c),
    .a              (reg_a),
    .b              (reg_b),
    .busy           (stall),
    .done_c         (mul_done_c),
    .product        (product),
    .product_next_c (product_next_c)
  );
`else
  assign stall = 1'b0;
`endif

  // Shared adder: SBC is A + ~B + C, ADC is A + B + C, ADD forces carry-in low.
  always_comb begin
    addend_c = reg_b;
    cin_c    = 1'b0;
    if (wb.i_wb_addr == ADDR_W'(ADDR_SBC)) addend_c = ~reg_b;
    if ((wb.i_wb_addr == ADDR_W'(ADDR_ADC)) || (wb.i_wb_addr == ADDR_W'(ADDR_SBC)))
      cin_c = flags[FLAG_C];
  end

  assign sum_c = (WIDTH+1)'(reg_a) + (WIDTH+1)'(addend_c) + (WIDTH+1)'(cin_c);

  // Read mux plus the FLAGS value an op read would commit.
  always_comb begin
    rdata_c    = '0;
    flags_rd_c = flags;
    op_c       = 1'b0;
    case (wb.i_wb_addr)
      ADDR_W'(ADDR_A):     rdata_c = reg_a;
      ADDR_W'(ADDR_B):     rdata_c = reg_b;
      ADDR_W'(ADDR_FLAGS): rdata_c = WIDTH'(flags);
`ifdef ALU_MUL_EN
      ADDR_W'(ADDR_PROD_LO): rdata_c = product[WIDTH-1:0];
      ADDR_W'(ADDR_PROD_HI): rdata_c = product[2*WIDTH-1:WIDTH];
`endif
      ADDR_W'(ADDR_ADD), ADDR_W'(ADDR_ADC), ADDR_W'(ADDR_SBC): begin
        op_c               = 1'b1;
        rdata_c            = sum_c[WIDTH-1:0];
        flags_rd_c[FLAG_C] = sum_c[WIDTH];
        flags_rd_c[FLAG_V] = (reg_a[WIDTH-1] == addend_c[WIDTH-1]) &&
                             (sum_c[WIDTH-1] != reg_a[WIDTH-1]);
      end
      ADDR_W'(ADDR_AND): begin op_c = 1'b1; rdata_c = reg_a & reg_b; end
      ADDR_W'(ADDR_OR):  begin op_c = 1'b1; rdata_c = reg_a | reg_b; end
      ADDR_W'(ADDR_XOR): begin op_c = 1'b1; rdata_c = reg_a ^ reg_b; end
      ADDR_W'(ADDR_ASL): begin
        op_c               = 1'b1;
        rdata_c            = {reg_a[WIDTH-2:0], 1'b0};
        flags_rd_c[FLAG_C] = reg_a[WIDTH-1];
      end
      ADDR_W'(ADDR_LSR): begin
        op_c               = 1'b1;
        rdata_c            = {1'b0, reg_a[WIDTH-1:1]};
        flags_rd_c[FLAG_C] = reg_a[0];
      end
      default: ;
    endcase
    if (op_c) begin
      flags_rd_c[FLAG_Z] = (rdata_c == '0);
      flags_rd_c[FLAG_N] = rdata_c[WIDTH-1];
    end
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      reg_a <= '0;
      reg_b <= '0;
      flags <= '0;
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= accept_c;
      if (accept_c && !wb.i_wb_we) begin
        rdata <= rdata_c;
        flags <= flags_rd_c;
      end
      if (accept_c && wb.i_wb_we) begin
        case (wb.i_wb_addr)
          ADDR_W'(ADDR_A):     reg_a <= wb.i_wb_data;
          ADDR_W'(ADDR_B):     reg_b <= wb.i_wb_data;
          ADDR_W'(ADDR_FLAGS): flags <= wb.i_wb_data[FLAGS_W-1:0] & FLAGS_MASK;
          default: ;
        endcase
      end
`ifdef ALU_MUL_EN
      // The bus is stalled while multiplying, so this never races a FLAGS write.
      if (mul_done_c) flags[FLAG_Z] <= (product_next_c == '0);
`endif
    end
  end

endmodule

// File: tb/tb_alu_wb_param.sv
// Directed bench for alu_wb_param (WIDTH=8); multiplier tests follow ALU_MUL_EN.
module tb_alu_wb_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   nack_cnt = 0;

  always #5 clk = ~clk;

  alu_wb_param_if #(.WIDTH(8), .ADDR_W(4)) bus_if ();

  alu_wb_param #(.WIDTH(8), .ADDR_W(4)) dut (
    .i_clk (clk),
    .reset (rst),
    .wb    (bus_if.slave)
  );

  // One request, held until accepted; returns read data, ack and the stall wait count.
  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output logic acked, output int waited);
    bus_if.i_wb_stb  = 1'b1;
    bus_if.i_wb_we   = we;
    bus_if.i_wb_addr = addr;
    bus_if.i_wb_data = wdata;
    waited = 0;
    while (bus_if.o_wb_stall !== 1'b0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    acked = bus_if.o_wb_ack;
    rdata = bus_if.o_wb_data;
    bus_if.i_wb_stb = 1'b0;
    bus_if.i_wb_we  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] d);
    logic [7:0] r; logic a; int w;
    bus_xfer(1'b1, addr, d, r, a, w);
    if (a !== 1'b1) nack_cnt++;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [7:0] d);
    logic a; int w;
    bus_xfer(1'b0, addr, 8'h00, d, a, w);
    if (a !== 1'b1) nack_cnt++;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    #1;
    vectors++; if (bus_if.o_wb_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", bus_if.o_wb_ack); end
    vectors++; if (bus_if.o_wb_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", bus_if.o_wb_stall); end
    vectors++; if (bus_if.o_wb_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", bus_if.o_wb_data); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    rd(4'h0, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_a got %h want 00", d); end
    rd(4'h1, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_b got %h want 00", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_flags got %h want 00", d); end
  endtask

  task automatic test_ack;
    logic [7:0] d; logic a; int w;
    wr(4'h0, 8'h50);
    bus_xfer(1'b1, 4'h1, 8'h50, d, a, w);
    vectors++; if (a !== 1'b1 || w !== 0) begin miscompares++; $display("FAIL ack_write got ack=%b wait=%0d want ack=1 wait=0", a, w); end
    @(posedge clk); #1;
    vectors++; if (bus_if.o_wb_ack !== 1'b0) begin miscompares++; $display("FAIL ack_drop got %b want 0", bus_if.o_wb_ack); end
    bus_xfer(1'b0, 4'h8, 8'h00, d, a, w);
    vectors++; if (a !== 1'b1 || d !== 8'hA0) begin miscompares++; $display("FAIL add_overflow got ack=%b data=%h want ack=1 data=a0", a, d); end
    rd(4'h2, d); vectors++; if (d !== 8'hC0) begin miscompares++; $display("FAIL add_overflow_flags got %h want c0", d); end
  endtask

  task automatic test_add_carry;
    logic [7:0] d;
    wr(4'h0, 8'hFF); wr(4'h1, 8'h01);
    rd(4'h8, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL add_wrap got %h want 00", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL add_wrap_flags got %h want 03", d); end
    wr(4'h0, 8'h00); wr(4'h1, 8'h00);
    rd(4'h9, d); vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL adc_cin got %h want 01", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL adc_cin_flags got %h want 00", d); end
  endtask

  task automatic test_sbc;
    logic [7:0] d;
    wr(4'h2, 8'h01); wr(4'h0, 8'h05); wr(4'h1, 8'h07);
    rd(4'hA, d); vectors++; if (d !== 8'hFE) begin miscompares++; $display("FAIL sbc_borrow got %h want fe", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL sbc_borrow_flags got %h want 80", d); end
    wr(4'h2, 8'h01); wr(4'h0, 8'h07); wr(4'h1, 8'h05);
    rd(4'hA, d); vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL sbc_noborrow got %h want 02", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL sbc_noborrow_flags got %h want 01", d); end
  endtask

  task automatic test_logic;
    logic [7:0] d;
    wr(4'h0, 8'hF0); wr(4'h1, 8'h3C);
    rd(4'hB, d); vectors++; if (d !== 8'h30) begin miscompares++; $display("FAIL and got %h want 30", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL and_flags got %h want 01", d); end
    rd(4'hC, d); vectors++; if (d !== 8'hFC) begin miscompares++; $display("FAIL or got %h want fc", d); end
    rd(4'hD, d); vectors++; if (d !== 8'hCC) begin miscompares++; $display("FAIL xor got %h want cc", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h81) begin miscompares++; $display("FAIL xor_flags got %h want 81", d); end
    wr(4'h0, 8'h0F); wr(4'h1, 8'hF0);
    rd(4'hB, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL and_zero got %h want 00", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL and_zero_flags got %h want 03", d); end
  endtask

  task automatic test_shift;
    logic [7:0] d;
    wr(4'h0, 8'h81);
    rd(4'hE, d); vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL asl got %h want 02", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL asl_flags got %h want 01", d); end
    rd(4'hF, d); vectors++; if (d !== 8'h40) begin miscompares++; $display("FAIL lsr got %h want 40", d); end
    rd(4'h2, d); vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL lsr_flags got %h want 01", d); end
    rd(4'h0, d); vectors++; if (d !== 8'h81) begin miscompares++; $display("FAIL a_unchanged got %h want 81", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    wr(4'h0, 8'h10); wr(4'h1, 8'h20); wr(4'h2, 8'h01);
    rd(4'h9, d); vectors++; if (d !== 8'h31) begin miscompares++; $display("FAIL b2b_adc_c1 got %h want 31", d); end
    wr(4'h2, 8'h00);
    rd(4'h9, d); vectors++; if (d !== 8'h30) begin miscompares++; $display("FAIL b2b_adc_c0 got %h want 30", d); end
    wr(4'h7, 8'hAA);
    rd(4'h0, d); vectors++; if (d !== 8'h10) begin miscompares++; $display("FAIL unmapped_write got %h want 10", d); end
    rd(4'h6, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL unmapped_read got %h want 00", d); end
    wr(4'h2, 8'hFF);
    rd(4'h2, d); vectors++; if (d !== 8'hC3) begin miscompares++; $display("FAIL flags_mask got %h want c3", d); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    logic [7:0] d; logic a; int w;
    wr(4'h0, 8'hFF); wr(4'h1, 8'hFF);
    bus_xfer(1'b1, 4'h3, 8'h00, d, a, w);
    vectors++; if (a !== 1'b1 || bus_if.o_wb_stall !== 1'b1) begin miscompares++; $display("FAIL mul_go got ack=%b stall=%b want 1 1", a, bus_if.o_wb_stall); end
    bus_xfer(1'b0, 4'h0, 8'h00, d, a, w);
    vectors++; if (w !== 8) begin miscompares++; $display("FAIL mul_stall_len got %0d want 8", w); end
    vectors++; if (a !== 1'b1 || d !== 8'hFF) begin miscompares++; $display("FAIL mul_held_read got ack=%b data=%h want 1 ff", a, d); end
    rd(4'h4, d); vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL mul_lo got %h want 01", d); end
    rd(4'h5, d); vectors++; if (d !== 8'hFE) begin miscompares++; $display("FAIL mul_hi got %h want fe", d); end
    rd(4'h2, d); vectors++; if (d !== 8'hC1) begin miscompares++; $display("FAIL mul_flags got %h want c1", d); end
    wr(4'h0, 8'h00); wr(4'h3, 8'h00);
    rd(4'h2, d); vectors++; if (d !== 8'hC3) begin miscompares++; $display("FAIL mul_zero_flags got %h want c3", d); end
  endtask

  task automatic test_mul_reset;
    logic [7:0] d; logic a; int w;
    wr(4'h0, 8'hFF); wr(4'h1, 8'hFF);
    rd(4'h0, d);
    bus_xfer(1'b1, 4'h3, 8'h00, d, a, w);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus_if.o_wb_stall !== 1'b0 || bus_if.o_wb_ack !== 1'b0 || bus_if.o_wb_data !== 8'h00) begin
      miscompares++; $display("FAIL mul_reset got stall=%b ack=%b data=%h want 0 0 00", bus_if.o_wb_stall, bus_if.o_wb_ack, bus_if.o_wb_data);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    rd(4'h4, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL mul_reset_prod got %h want 00", d); end
    wr(4'h0, 8'h03); wr(4'h1, 8'h05); wr(4'h3, 8'h00);
    bus_xfer(1'b0, 4'h4, 8'h00, d, a, w);
    vectors++; if (w !== 8 || d !== 8'h0F) begin miscompares++; $display("FAIL mul_after_reset got wait=%0d data=%h want 8 0f", w, d); end
    rd(4'h5, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL mul_after_reset_hi got %h want 00", d); end
  endtask
`else
  task automatic test_mul_disabled;
    logic [7:0] d; logic a; int w;
    wr(4'h0, 8'h03); wr(4'h1, 8'h05);
    bus_xfer(1'b1, 4'h3, 8'h00, d, a, w);
    vectors++; if (a !== 1'b1 || bus_if.o_wb_stall !== 1'b0) begin miscompares++; $display("FAIL nomul_go got ack=%b stall=%b want 1 0", a, bus_if.o_wb_stall); end
    bus_xfer(1'b0, 4'h4, 8'h00, d, a, w);
    vectors++; if (w !== 0 || d !== 8'h00) begin miscompares++; $display("FAIL nomul_lo got wait=%0d data=%h want 0 00", w, d); end
    rd(4'h5, d); vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL nomul_hi got %h want 00", d); end
  endtask
`endif

  initial begin
    bus_if.i_wb_stb  = 1'b0;
    bus_if.i_wb_we   = 1'b0;
    bus_if.i_wb_addr = 4'h0;
    bus_if.i_wb_data = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_ack();
    test_add_carry();
    test_sbc();
    test_logic();
    test_shift();
    test_back_to_back();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    vectors++; if (nack_cnt !== 0) begin miscompares++; $display("FAIL missing_acks got %0d want 0", nack_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
